d_shift_reg: RTL and testbench

// Parametrised, clocked successor to the level-sensitive single-bit D storage element.
// It holds a WIDTH-bit word with enable-gated hold, parallel load and single-step shift.
// It also runs an autonomous burst-shift sequence of a requested length, with busy/done status.
// It serves as the general storage and serialiser element for datapath and serial-link blocks.

---
 rtl/d_shift_reg.sv | 121 ++++++++++++
 tb/tb_d_shift_reg.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/d_shift_reg.sv
// d_shift_reg: WIDTH-bit storage/serialiser word with enable-gated hold,
// parallel load, single-step shift and an autonomous burst-shift sequencer
// that reports busy while shifting and a one-cycle done at completion.
module d_shift_reg #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  localparam int unsigned         CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic             dir,
  input  logic [CW-1:0]    shamt,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] WMAX = CW'(WIDTH);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            dir_r;
  logic [CW-1:0]   shamt_clamp;
  logic [WIDTH-1:0] q_shr;
  logic [WIDTH-1:0] q_shl;

  // Shift candidates and the clamped burst length.
  always_comb begin
    q_shr       = {sin, q[WIDTH-1:1]};
    q_shl       = {q[WIDTH-2:0], sin};
    shamt_clamp = (shamt > WMAX) ? WMAX : shamt;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and status outputs; DONE always lasts one cycle.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (ena && start) state_nxt = (shamt_clamp == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (ena && (cnt == CW'(1))) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: word, serial-out bit, burst counter and latched direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= RESET_VAL;
      sout  <= 1'b0;
      cnt   <= '0;
      dir_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ena) begin
            if (start) begin
              cnt   <= shamt_clamp;
              dir_r <= dir;
            end else begin
              case (mode)
                2'b01: q <= d;
                2'b10: begin
                  q    <= q_shr;
                  sout <= q[0];
                end
                2'b11: begin
                  q    <= q_shl;
                  sout <= q[WIDTH-1];
                end
                default: ;
              endcase
            end
          end
        end
        SHIFT: begin
          if (ena) begin
            cnt <= cnt - CW'(1);
            if (dir_r) begin
              q    <= q_shl;
              sout <= q[WIDTH-1];
            end else begin
              q    <= q_shr;
              sout <= q[0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_d_shift_reg.sv
// tb_d_shift_reg: directed stimulus pushes hand-computed per-cycle output
// expectations into a scoreboard queue; an independent monitor pops and
// compares them on the falling edge and counts done pulses.
module tb_d_shift_reg;

  localparam int unsigned    WIDTH = 8;
  localparam int unsigned    CW    = $clog2(WIDTH + 1);
  localparam logic [7:0]     RV    = 8'h3C;
  localparam int unsigned    EXP_DONES = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             ena;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic             start;
  logic             dir;
  logic [CW-1:0]    shamt;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  d_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .ena(ena), .mode(mode), .d(d), .sin(sin),
    .start(start), .dir(dir), .shamt(shamt), .q(q), .sout(sout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  q;
    logic        sout;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned dones_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare all expectations tagged with the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) chk("stale_entry", e.cyc, cyc);
      else begin
        chk("q",    {24'd0, q},    {24'd0, e.q});
        chk("sout", {31'd0, sout}, {31'd0, e.sout});
        chk("busy", {31'd0, busy}, {31'd0, e.busy});
        chk("done", {31'd0, done}, {31'd0, e.done});
      end
    end
    if (done === 1'b1) dones_seen++;
  end

  // Advance one clock and record what the outputs must be after that edge.
  task automatic tick(input logic [7:0] eq, input logic es, input logic eb, input logic ed);
    exp_t e;
    @(posedge clk);
    #1;
    e.cyc = cyc; e.q = eq; e.sout = es; e.busy = eb; e.done = ed;
    sb.push_back(e);
  endtask

  initial begin
    // Reset with random inputs.
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ena = 1'($urandom); mode = 2'($urandom); d = 8'($urandom); sin = 1'($urandom);
      start = 1'($urandom); dir = 1'($urandom); shamt = CW'($urandom_range(0, 12));
      tick(RV, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0; ena = 1'b1; start = 1'b0; dir = 1'b0; shamt = '0; sin = 1'b0;

    // Load and single steps.
    mode = 2'b01; d = 8'hA5;          tick(8'hA5, 1'b0, 1'b0, 1'b0);
    mode = 2'b10; sin = 1'b1;         tick(8'hD2, 1'b1, 1'b0, 1'b0);
    mode = 2'b11; sin = 1'b0;         tick(8'hA4, 1'b1, 1'b0, 1'b0);
    // ena low in IDLE ignores mode and start.
    ena = 1'b0; mode = 2'b01; d = 8'h00; start = 1'b1; shamt = CW'(3);
                                      tick(8'hA4, 1'b1, 1'b0, 1'b0);
    ena = 1'b1; start = 1'b0; mode = 2'b00;
                                      tick(8'hA4, 1'b1, 1'b0, 1'b0);

    // Left burst of 3 from 0x81.
    mode = 2'b01; d = 8'h81;          tick(8'h81, 1'b1, 1'b0, 1'b0);
    mode = 2'b00; start = 1'b1; dir = 1'b1; shamt = CW'(3); sin = 1'b0;
                                      tick(8'h81, 1'b1, 1'b1, 1'b0);
    start = 1'b0;                     tick(8'h02, 1'b1, 1'b1, 1'b0);
                                      tick(8'h04, 1'b0, 1'b1, 1'b0);
                                      tick(8'h08, 1'b0, 1'b0, 1'b1);
    // start during DONE is ignored.
    start = 1'b1; shamt = CW'(2);     tick(8'h08, 1'b0, 1'b0, 1'b0);
    start = 1'b0;                     tick(8'h08, 1'b0, 1'b0, 1'b0);

    // Right burst of 4 with a 2-cycle pause.
    mode = 2'b01; d = 8'hF5;          tick(8'hF5, 1'b0, 1'b0, 1'b0);
    mode = 2'b00; start = 1'b1; dir = 1'b0; shamt = CW'(4); sin = 1'b1;
                                      tick(8'hF5, 1'b0, 1'b1, 1'b0);
    start = 1'b0;                     tick(8'hFA, 1'b1, 1'b1, 1'b0);
                                      tick(8'hFD, 1'b0, 1'b1, 1'b0);
    ena = 1'b0;                       tick(8'hFD, 1'b0, 1'b1, 1'b0);
                                      tick(8'hFD, 1'b0, 1'b1, 1'b0);
    ena = 1'b1;                       tick(8'hFE, 1'b1, 1'b1, 1'b0);
                                      tick(8'hFF, 1'b0, 1'b0, 1'b1);
                                      tick(8'hFF, 1'b0, 1'b0, 1'b0);

    // shamt=0: straight to DONE, q unchanged.
    start = 1'b1; shamt = '0;         tick(8'hFF, 1'b0, 1'b0, 1'b1);
    start = 1'b0;                     tick(8'hFF, 1'b0, 1'b0, 1'b0);

    // shamt=12 clamps to 8 shifts of sin=1.
    mode = 2'b01; d = 8'h00;          tick(8'h00, 1'b0, 1'b0, 1'b0);
    mode = 2'b00; start = 1'b1; dir = 1'b0; shamt = CW'(12); sin = 1'b1;
                                      tick(8'h00, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    begin
      logic [7:0] tbl [7] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE};
      for (int i = 0; i < 7; i++) tick(tbl[i], 1'b0, 1'b1, 1'b0);
    end
                                      tick(8'hFF, 1'b0, 1'b0, 1'b1);
                                      tick(8'hFF, 1'b0, 1'b0, 1'b0);

    // Reset at the 2nd shift cycle aborts without done.
    start = 1'b1; dir = 1'b1; shamt = CW'(4); sin = 1'b0;
                                      tick(8'hFF, 1'b0, 1'b1, 1'b0);
    start = 1'b0;                     tick(8'hFE, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;                     tick(RV, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++)       tick(RV, 1'b0, 1'b0, 1'b0);

    // start has priority over mode=01; d is not loaded.
    start = 1'b1; mode = 2'b01; d = 8'hAA; dir = 1'b0; shamt = CW'(1); sin = 1'b0;
                                      tick(RV, 1'b0, 1'b1, 1'b0);
    start = 1'b0; mode = 2'b00;       tick(8'h1E, 1'b0, 1'b0, 1'b1);
                                      tick(8'h1E, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    chk("done_count", dones_seen, EXP_DONES);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
